// File: rtl/rvm_fetch_ctrl_pkg.sv
// Shared types and constants for the rvm instruction-fetch controller.
// Optional feature macro: RVM_FETCH_TRAP_EN (see rvm_fetch_ctrl).
package rvm_fetch_ctrl_pkg;

   localparam int RVM_FETCH_STATE_W = 2;

   typedef enum logic [RVM_FETCH_STATE_W-1:0] {
      RVM_FETCH_POST_RESET = 2'd0,
      RVM_FETCH_FETCH      = 2'd1,
      RVM_FETCH_ISSUE      = 2'd2,
      RVM_FETCH_HALT       = 2'd3
   } fetch_state_e;

   localparam logic [3:0] RVM_FETCH_BYTE_EN = 4'b1111;

   function automatic logic misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/rvm_fetch_stall_timer.sv
// Saturating count of consecutive stalled fetch cycles.
// expire flags the stall cycle that would reach MAX_STALL.
module rvm_fetch_stall_timer #(
   parameter int MAX_STALL = 16
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic inc,
   output logic expire
);

   localparam int CW = $clog2(MAX_STALL + 1);
   localparam logic [CW-1:0] LIMIT = CW'(MAX_STALL);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && count != LIMIT) begin
         count <= count + 1'b1;
      end
   end

   assign expire = inc && (count == LIMIT - 1'b1);

endmodule

// File: rtl/rvm_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the memory port, issues words.
// Define RVM_FETCH_TRAP_EN to vector faults to TRAP_VECTOR instead of halting.
module rvm_fetch_ctrl
   import rvm_fetch_ctrl_pkg::*;
#(
   parameter int               XLEN         = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
   parameter int               PC_STEP      = 4,
   parameter int               MAX_STALL    = 16
`ifdef RVM_FETCH_TRAP_EN
   ,parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100)
`endif
) (
   input  logic            clk,
   input  logic            resetn,
   output logic [XLEN-1:0] mem_addr,
   input  logic [31:0]     mem_rdata,
   output logic            mem_c_en,
   output logic [3:0]      mem_b_en,
   input  logic            mem_error,
   input  logic            mem_stall,
   output logic            f_instr_valid,
   input  logic            f_instr_ready,
   output logic [31:0]     f_instr,
   output logic [XLEN-1:0] f_instr_pc,
   input  logic            s_redirect,
   input  logic [XLEN-1:0] s_redirect_pc,
   output logic            f_halted,
   output logic            f_fault
);

   fetch_state_e    state;
   logic [XLEN-1:0] pc;
   logic            pend;
   logic [XLEN-1:0] pend_pc;

   logic            in_fetch;
   logic            in_issue;
   logic            done;
   logic            handshake;
   logic            pend_now;
   logic [XLEN-1:0] pend_tgt;
   logic            stall_expire;
   logic            fault;

   assign in_fetch  = (state == RVM_FETCH_FETCH);
   assign in_issue  = (state == RVM_FETCH_ISSUE);
   assign done      = in_fetch & ~mem_stall;
   assign handshake = f_instr_valid & f_instr_ready;

   // A redirect arriving on the completion cycle itself wins over the latched one.
   assign pend_now  = s_redirect | pend;
   assign pend_tgt  = s_redirect ? s_redirect_pc : pend_pc;

   assign mem_addr  = pc;
   assign mem_b_en  = RVM_FETCH_BYTE_EN;

   rvm_fetch_stall_timer #(
      .MAX_STALL (MAX_STALL)
   ) u_stall_timer (
      .clk    (clk),
      .resetn (resetn),
      .clr    (~in_fetch | ~mem_stall | stall_expire),
      .inc    (in_fetch & mem_stall),
      .expire (stall_expire)
   );

   always_comb begin
      fault = 1'b0;
      unique case (1'b1)
         in_fetch: fault = stall_expire
                         | (done & mem_error)
                         | (done & pend_now & misaligned(pend_tgt[1:0]));
         in_issue: fault = s_redirect & misaligned(s_redirect_pc[1:0]);
         default:  fault = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= RVM_FETCH_POST_RESET;
         pc            <= RESET_VECTOR;
         mem_c_en      <= 1'b0;
         f_instr_valid <= 1'b0;
         f_instr       <= '0;
         f_instr_pc    <= '0;
         f_halted      <= 1'b0;
         f_fault       <= 1'b0;
         pend          <= 1'b0;
         pend_pc       <= '0;
      end else begin
         f_fault <= 1'b0;
         if (fault) begin
            f_fault       <= 1'b1;
            pend          <= 1'b0;
            f_instr_valid <= 1'b0;
`ifdef RVM_FETCH_TRAP_EN
            pc            <= TRAP_VECTOR;
            state         <= RVM_FETCH_FETCH;
            mem_c_en      <= 1'b1;
`else
            state         <= RVM_FETCH_HALT;
            mem_c_en      <= 1'b0;
            f_halted      <= 1'b1;
`endif
         end else begin
            unique case (state)
               RVM_FETCH_POST_RESET: begin
                  state    <= RVM_FETCH_FETCH;
                  mem_c_en <= 1'b1;
               end
               RVM_FETCH_FETCH: begin
                  if (done) begin
                     pend <= 1'b0;
                     if (pend_now) begin
                        pc <= pend_tgt;
                     end else begin
                        f_instr       <= mem_rdata;
                        f_instr_pc    <= pc;
                        f_instr_valid <= 1'b1;
                        mem_c_en      <= 1'b0;
                        state         <= RVM_FETCH_ISSUE;
                     end
                  end else if (s_redirect) begin
                     pend    <= 1'b1;
                     pend_pc <= s_redirect_pc;
                  end
               end
               RVM_FETCH_ISSUE: begin
                  if (s_redirect | handshake) begin
                     pc            <= s_redirect ? s_redirect_pc
                                                 : pc + XLEN'(PC_STEP);
                     f_instr_valid <= 1'b0;
                     mem_c_en      <= 1'b1;
                     state         <= RVM_FETCH_FETCH;
                  end
               end
               RVM_FETCH_HALT: begin
                  mem_c_en      <= 1'b0;
                  f_instr_valid <= 1'b0;
                  f_halted      <= 1'b1;
               end
               default: begin
                  state         <= RVM_FETCH_POST_RESET;
                  mem_c_en      <= 1'b0;
                  f_instr_valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rvm_fetch_ctrl.sv
// Randomized scoreboard bench for rvm_fetch_ctrl.
// Honors RVM_FETCH_TRAP_EN when the design is built with it.
module tb_rvm_fetch_ctrl;

   localparam int          MAXS = 4;
   localparam logic [31:0] RV   = 32'hFFFF_FFFC;
   localparam logic [31:0] TRAP = 32'h0000_0100;
   localparam int          NEP  = 10;
   localparam int          NCYC = 300;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_c_en;
   logic [3:0]  mem_b_en;
   logic        mem_error = 1'b0;
   logic        mem_stall = 1'b0;
   logic        f_instr_valid;
   logic        f_instr_ready = 1'b0;
   logic [31:0] f_instr;
   logic [31:0] f_instr_pc;
   logic        s_redirect = 1'b0;
   logic [31:0] s_redirect_pc = '0;
   logic        f_halted;
   logic        f_fault;

   always #5 clk = ~clk;

   rvm_fetch_ctrl #(
      .XLEN         (32),
      .RESET_VECTOR (RV),
      .PC_STEP      (4),
      .MAX_STALL    (MAXS)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .mem_addr      (mem_addr),
      .mem_rdata     (mem_rdata),
      .mem_c_en      (mem_c_en),
      .mem_b_en      (mem_b_en),
      .mem_error     (mem_error),
      .mem_stall     (mem_stall),
      .f_instr_valid (f_instr_valid),
      .f_instr_ready (f_instr_ready),
      .f_instr       (f_instr),
      .f_instr_pc    (f_instr_pc),
      .s_redirect    (s_redirect),
      .s_redirect_pc (s_redirect_pc),
      .f_halted      (f_halted),
      .f_fault       (f_fault)
   );

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
   endfunction

   assign mem_rdata = memf(mem_addr);

   typedef struct packed {
      logic        is_fault;
      logic [31:0] pc;
      logic [31:0] instr;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   // Architectural view: PC of the next instruction to be delivered.
   logic [31:0] m_pc;
   logic [31:0] m_pend_pc;
   bit          m_pend;
   bit          m_halted;
   int          m_run;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push_ev(input logic flt, input logic [31:0] pc);
      ev_t e;
      e.is_fault = flt;
      e.pc       = flt ? 32'h0 : pc;
      e.instr    = flt ? 32'h0 : memf(pc);
      exp_q.push_back(e);
   endtask

   task automatic observe(input logic flt, input logic [31:0] pc,
                          input logic [31:0] instr);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event actual=fault:%0d pc=%h required=none",
                  flt, pc);
      end else begin
         e = exp_q.pop_front();
         if (e.is_fault !== flt || (!flt && (e.pc !== pc || e.instr !== instr))) begin
            errors++;
            $display("FAIL event actual=fault:%0d pc=%h instr=%h required=fault:%0d pc=%h instr=%h",
                     flt, pc, instr, e.is_fault, e.pc, e.instr);
         end
      end
   endtask

   always @(negedge clk) begin
      #3;
      if (resetn) begin
         if (f_instr_valid && f_instr_ready)
            observe(1'b0, f_instr_pc, f_instr);
         if (f_fault)
            observe(1'b1, 32'h0, 32'h0);
      end
   end

   task automatic model_reset();
      m_pc      = RV;
      m_pend    = 1'b0;
      m_pend_pc = '0;
      m_halted  = 1'b0;
      m_run     = 0;
   endtask

   task automatic model_step();
      bit flt;
      flt = 1'b0;
      if (m_halted) return;
      if (f_instr_valid) begin
         if (f_instr_ready) begin
            push_ev(1'b0, m_pc);
            m_pc = m_pc + 32'd4;
         end
         if (s_redirect) begin
            if (s_redirect_pc[1:0] != 2'b00) flt = 1'b1;
            else m_pc = s_redirect_pc;
         end
      end else if (mem_c_en) begin
         chk("fetch_addr", mem_addr, m_pc);
         if (s_redirect) begin
            m_pend    = 1'b1;
            m_pend_pc = s_redirect_pc;
         end
         if (mem_stall) begin
            m_run++;
            if (m_run == MAXS) flt = 1'b1;
         end else begin
            m_run = 0;
            if (mem_error) begin
               flt = 1'b1;
            end else if (m_pend) begin
               if (m_pend_pc[1:0] != 2'b00) flt = 1'b1;
               else m_pc = m_pend_pc;
               m_pend = 1'b0;
            end
         end
      end
      if (flt) begin
         push_ev(1'b1, 32'h0);
         m_pend = 1'b0;
         m_run  = 0;
`ifdef RVM_FETCH_TRAP_EN
         m_pc = TRAP;
`else
         m_halted = 1'b1;
`endif
      end
   endtask

   int st_p  [NEP] = '{0, 30, 100, 30, 25, 40, 10, 20, 50, 15};
   int er_p  [NEP] = '{0, 0, 0, 0, 3, 2, 1, 0, 2, 0};
   int rd_p  [NEP] = '{0, 0, 0, 10, 8, 5, 15, 3, 10, 20};
   int mis_p [NEP] = '{0, 0, 0, 0, 20, 10, 10, 30, 15, 5};
   int rdy_p [NEP] = '{100, 100, 100, 70, 60, 50, 90, 80, 40, 100};

   initial begin
      logic [31:0] t;
      for (int ep = 0; ep < NEP; ep++) begin
         @(negedge clk);
         resetn        = 1'b0;
         mem_stall     = 1'b0;
         mem_error     = 1'b0;
         f_instr_ready = 1'b0;
         s_redirect    = 1'b0;
         model_reset();
         @(negedge clk);
         #1;
         chk("rst_c_en", {31'b0, mem_c_en}, 32'd0);
         chk("rst_valid", {31'b0, f_instr_valid}, 32'd0);
         chk("rst_instr", f_instr, 32'd0);
         chk("rst_instr_pc", f_instr_pc, 32'd0);
         chk("rst_halted", {31'b0, f_halted}, 32'd0);
         chk("rst_fault", {31'b0, f_fault}, 32'd0);
         chk("rst_addr", mem_addr, RV);
         chk("b_en", {28'b0, mem_b_en}, 32'hF);
         @(negedge clk);
         resetn = 1'b1;
         for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            mem_stall     = ($urandom_range(0, 99) < st_p[ep]);
            mem_error     = ($urandom_range(0, 99) < er_p[ep]);
            f_instr_ready = ($urandom_range(0, 99) < rdy_p[ep]);
            s_redirect    = ($urandom_range(0, 99) < rd_p[ep]);
            t = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if ($urandom_range(0, 7) == 0) t = t | 32'hFFFF_F000;
            if ($urandom_range(0, 99) < mis_p[ep])
               t[1:0] = 2'($urandom_range(1, 3));
            s_redirect_pc = t;
            model_step();
         end
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_stall     = 1'b0;
            mem_error     = 1'b0;
            f_instr_ready = 1'b0;
            s_redirect    = 1'b0;
            model_step();
         end
         #4;
         chk("queue_drained", 32'(exp_q.size()), 32'd0);
         chk("halted", {31'b0, f_halted}, {31'b0, m_halted});
         exp_q.delete();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
